// File: rtl/md_pkg.sv
// Shared op codes, FSM state encoding and unit-select codes for the HI/LO
// multiply/divide controller.
package md_pkg;

   localparam logic [2:0] MD_NONE = 3'd0;
   localparam logic [2:0] MULT    = 3'd1;
   localparam logic [2:0] MULTU   = 3'd2;
   localparam logic [2:0] DIV     = 3'd3;
   localparam logic [2:0] DIVU    = 3'd4;
   localparam logic [2:0] MTHI    = 3'd5;
   localparam logic [2:0] MTLO    = 3'd6;

   localparam logic [1:0] CHOOSE_MUL  = 2'b11;
   localparam logic [1:0] CHOOSE_DIV  = 2'b01;
   localparam logic [1:0] CHOOSE_IDLE = 2'b00;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BUSY    = 2'd1,
      S_RELEASE = 2'd2,
      S_ABORT   = 2'd3
   } md_state_e;

   function automatic logic is_muldiv(input logic [2:0] op);
      return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
   endfunction

   function automatic logic is_hilo_wr(input logic [2:0] op);
      return (op == MTHI) || (op == MTLO);
   endfunction

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI and LO registers, each with its own write enable.
module hilo_regs (
   input  logic        clk,
   input  logic        rst,
   input  logic        hi_we,
   input  logic [31:0] hi_d,
   input  logic        lo_we,
   input  logic [31:0] lo_d,
   output logic [31:0] hi_q,
   output logic [31:0] lo_q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         if (hi_we) hi_q <= hi_d;
         if (lo_we) lo_q <= lo_d;
      end
   end

endmodule

// File: rtl/hilo_md_ctrl.sv
// EX-stage controller: issues mul/div to the iterative unit, stalls the pipe
// while it runs, commits the 64-bit result to HI/LO and services MTHI/MTLO.
module hilo_md_ctrl
   import md_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [2:0]  ex_md_op,
   input  logic [31:0] ex_rs,
   input  logic [31:0] ex_rt,
   input  logic        flush,
   input  logic [63:0] md_result,
   input  logic        md_ready,
   output logic        md_start,
   output logic        md_annul,
   output logic        md_signed,
   output logic [31:0] md_op1,
   output logic [31:0] md_op2,
   output logic [1:0]  md_choose,
   output logic        stall_req,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output md_state_e   dbg_state
);

   // Unit handshake: md_start stays high for the whole operation with the
   // operands frozen; md_ready is a one-cycle result-valid pulse taken only
   // while BUSY and not flushed; md_annul aborts; md_choose=00 frees the unit.
   md_state_e   state;
   logic        abort_cnt;
   logic        issue, wr, commit;
   logic        hi_we, lo_we;
   logic [31:0] hi_d, lo_d;

   assign issue  = ex_valid & ~flush & is_muldiv(ex_md_op);
   assign wr     = ex_valid & ~flush & is_hilo_wr(ex_md_op);
   assign commit = (state == S_BUSY) & md_ready & ~flush;

   assign hi_we = commit | ((state == S_IDLE) & wr & (ex_md_op == MTHI));
   assign lo_we = commit | ((state == S_IDLE) & wr & (ex_md_op == MTLO));
   assign hi_d  = commit ? md_result[63:32] : ex_rs;
   assign lo_d  = commit ? md_result[31:0]  : ex_rs;

   // While aborting, a following HI/LO-touching op must wait for the unit.
   assign stall_req = ((state == S_IDLE) & issue)
                    | (state == S_BUSY)
                    | ((state == S_ABORT) & ex_valid
                       & (is_muldiv(ex_md_op) | is_hilo_wr(ex_md_op)));

   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         abort_cnt <= 1'b0;
         md_start  <= 1'b0;
         md_annul  <= 1'b0;
         md_signed <= 1'b0;
         md_op1    <= '0;
         md_op2    <= '0;
         md_choose <= CHOOSE_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (issue) begin
                  md_op1    <= ex_rs;
                  md_op2    <= ex_rt;
                  md_signed <= (ex_md_op == MULT) || (ex_md_op == DIV);
                  md_choose <= ((ex_md_op == MULT) || (ex_md_op == MULTU))
                               ? CHOOSE_MUL : CHOOSE_DIV;
                  md_start  <= 1'b1;
                  state     <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (flush) begin
                  md_start  <= 1'b0;
                  md_annul  <= 1'b1;
                  abort_cnt <= 1'b0;
                  state     <= S_ABORT;
               end else if (md_ready) begin
                  md_start <= 1'b0;
                  state    <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               md_choose <= CHOOSE_IDLE;
               state     <= S_IDLE;
            end
            S_ABORT: begin
               if (abort_cnt) begin
                  md_annul  <= 1'b0;
                  md_choose <= CHOOSE_IDLE;
                  state     <= S_IDLE;
               end else begin
                  abort_cnt <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   hilo_regs u_hilo_regs (
      .clk   (clk),
      .rst   (rst),
      .hi_we (hi_we),
      .hi_d  (hi_d),
      .lo_we (lo_we),
      .lo_d  (lo_d),
      .hi_q  (hi_o),
      .lo_q  (lo_o)
   );

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Directed bench for hilo_md_ctrl with a behavioural iterative mul/div unit.
module tb_hilo_md_ctrl;
   import md_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic [2:0]  ex_md_op;
   logic [31:0] ex_rs, ex_rt;
   logic        flush;
   logic [63:0] md_result;
   logic        md_ready;
   logic        md_start, md_annul, md_signed;
   logic [31:0] md_op1, md_op2;
   logic [1:0]  md_choose;
   logic        stall_req;
   logic [31:0] hi_o, lo_o;
   md_state_e   dbg_state;

   int total = 0;
   int bad   = 0;
   int unit_lat = 3;
   int u_cnt = 0;
   logic [31:0] exp_hi = '0, exp_lo = '0;

   always #5 clk = ~clk;

   hilo_md_ctrl dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_md_op(ex_md_op),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .flush(flush), .md_result(md_result),
      .md_ready(md_ready), .md_start(md_start), .md_annul(md_annul),
      .md_signed(md_signed), .md_op1(md_op1), .md_op2(md_op2),
      .md_choose(md_choose), .stall_req(stall_req), .hi_o(hi_o), .lo_o(lo_o),
      .dbg_state(dbg_state)
   );

   function automatic logic [63:0] unit_calc(input logic [1:0] ch, input logic sg,
                                             input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sp;
      if (ch == CHOOSE_MUL) begin
         if (sg) begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            return sp;
         end
         return {32'b0, a} * {32'b0, b};
      end
      if (b == 32'd0) return 64'd0;
      if (sg) return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      return {a % b, a / b};
   endfunction

   // Behavioural unit: result pulse unit_lat+1 cycles into the operation.
   always @(posedge clk) begin
      if (rst || md_annul || !md_start || md_choose == CHOOSE_IDLE) begin
         u_cnt    <= 0;
         md_ready <= 1'b0;
      end else if (u_cnt == unit_lat) begin
         md_ready  <= 1'b1;
         md_result <= unit_calc(md_choose, md_signed, md_op1, md_op2);
         u_cnt     <= u_cnt + 1;
      end else begin
         md_ready <= 1'b0;
         u_cnt    <= u_cnt + 1;
      end
   end

   task automatic idle_ex();
      ex_valid = 1'b0; ex_md_op = MD_NONE; ex_rs = '0; ex_rt = '0;
   endtask

   task automatic drive_ex(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
      ex_valid = 1'b1; ex_md_op = op; ex_rs = rs; ex_rt = rt;
   endtask

   // Issues one mul/div from IDLE and follows it to the RELEASE cycle.
   task automatic issue_and_wait(input string nm, input logic [2:0] op,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [1:0] ch, input logic sg,
                                 input logic [31:0] hi_e, input logic [31:0] lo_e);
      int cyc;
      @(negedge clk);
      drive_ex(op, rs, rt);
      #1;
      total++; if (stall_req !== 1'b1) begin bad++; $display("FAIL %s issue_stall got=%b exp=1", nm, stall_req); end
      @(negedge clk);
      total++; if (dbg_state !== S_BUSY || md_start !== 1'b1) begin bad++; $display("FAIL %s busy_start got state=%0d start=%b exp state=1 start=1", nm, dbg_state, md_start); end
      total++; if (md_choose !== ch || md_signed !== sg) begin bad++; $display("FAIL %s choose_signed got=%b/%b exp=%b/%b", nm, md_choose, md_signed, ch, sg); end
      cyc = 0;
      while (md_ready !== 1'b1 && cyc < 100) begin
         total++;
         if (stall_req !== 1'b1 || md_op1 !== rs || md_op2 !== rt || md_start !== 1'b1) begin
            bad++; $display("FAIL %s busy_hold got stall=%b op1=%h op2=%h exp stall=1 op1=%h op2=%h", nm, stall_req, md_op1, md_op2, rs, rt);
         end
         @(negedge clk);
         cyc++;
      end
      total++;
      if (cyc >= 100) begin bad++; $display("FAIL %s ready_timeout got=0 exp=1", nm); end
      else begin
         @(negedge clk);
         exp_hi = hi_e; exp_lo = lo_e;
         total++; if (dbg_state !== S_RELEASE || stall_req !== 1'b0 || md_start !== 1'b0 || md_choose !== ch) begin
            bad++; $display("FAIL %s release got state=%0d stall=%b start=%b choose=%b exp 2/0/0/%b", nm, dbg_state, stall_req, md_start, md_choose, ch);
         end
         total++; if (hi_o !== hi_e || lo_o !== lo_e) begin bad++; $display("FAIL %s hilo got=%h/%h exp=%h/%h", nm, hi_o, lo_o, hi_e, lo_e); end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; idle_ex();
      repeat (2) @(negedge clk);
      total++;
      if (dbg_state !== S_IDLE || hi_o !== 32'd0 || lo_o !== 32'd0 || md_start !== 1'b0 || md_annul !== 1'b0
          || md_signed !== 1'b0 || md_op1 !== 32'd0 || md_op2 !== 32'd0 || md_choose !== 2'b00 || stall_req !== 1'b0) begin
         bad++; $display("FAIL reset_state got st=%0d hi=%h lo=%h start=%b annul=%b ch=%b stall=%b exp all zero", dbg_state, hi_o, lo_o, md_start, md_annul, md_choose, stall_req);
      end
      rst = 1'b0;
   endtask

   task automatic test_mult();
      unit_lat = 4;
      issue_and_wait("mult", MULT, 32'hFFFFFFFD, 32'd5, 2'b11, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1);
      @(negedge clk);
      idle_ex();
      total++; if (dbg_state !== S_IDLE || md_choose !== 2'b00) begin bad++; $display("FAIL mult_no_reissue got state=%0d choose=%b exp 0/00", dbg_state, md_choose); end
   endtask

   task automatic test_div();
      unit_lat = 2;
      issue_and_wait("divu", DIVU, 32'd7, 32'd2, 2'b01, 1'b0, 32'd1, 32'd3);
      issue_and_wait("div", DIV, 32'hFFFFFFF9, 32'd2, 2'b01, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
      @(negedge clk);
      idle_ex();
   endtask

   task automatic test_mthi_mtlo();
      @(negedge clk);
      drive_ex(MTHI, 32'h12345678, 32'd0);
      #1; total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL mthi_stall got=%b exp=0", stall_req); end
      @(negedge clk);
      total++; if (hi_o !== 32'h12345678 || lo_o !== exp_lo) begin bad++; $display("FAIL mthi_write got=%h/%h exp=%h/%h", hi_o, lo_o, 32'h12345678, exp_lo); end
      drive_ex(MTLO, 32'h9ABCDEF0, 32'd0);
      #1; total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL mtlo_stall got=%b exp=0", stall_req); end
      @(negedge clk);
      idle_ex();
      exp_hi = 32'h12345678; exp_lo = 32'h9ABCDEF0;
      total++; if (hi_o !== exp_hi || lo_o !== exp_lo) begin bad++; $display("FAIL mtlo_write got=%h/%h exp=%h/%h", hi_o, lo_o, exp_hi, exp_lo); end
   endtask

   task automatic test_flush_busy();
      unit_lat = 30;
      @(negedge clk);
      drive_ex(MULT, 32'd11, 32'd13);
      repeat (10) @(negedge clk);
      total++; if (dbg_state !== S_BUSY) begin bad++; $display("FAIL flush_pre_busy got=%0d exp=1", dbg_state); end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; idle_ex();
      #1;
      total++; if (dbg_state !== S_ABORT || md_start !== 1'b0 || md_annul !== 1'b1 || md_choose !== 2'b11 || stall_req !== 1'b0) begin
         bad++; $display("FAIL abort_cyc1 got st=%0d start=%b annul=%b ch=%b stall=%b exp 3/0/1/11/0", dbg_state, md_start, md_annul, md_choose, stall_req);
      end
      total++; if (hi_o !== exp_hi || lo_o !== exp_lo) begin bad++; $display("FAIL abort_hilo got=%h/%h exp=%h/%h", hi_o, lo_o, exp_hi, exp_lo); end
      @(negedge clk);
      drive_ex(MTHI, 32'hDEADBEEF, 32'd0);
      #1;
      total++; if (dbg_state !== S_ABORT || md_annul !== 1'b1 || stall_req !== 1'b1) begin
         bad++; $display("FAIL abort_cyc2 got st=%0d annul=%b stall=%b exp 3/1/1", dbg_state, md_annul, stall_req);
      end
      @(negedge clk);
      idle_ex();
      total++; if (dbg_state !== S_IDLE || md_annul !== 1'b0 || md_choose !== 2'b00 || hi_o !== exp_hi) begin
         bad++; $display("FAIL abort_done got st=%0d annul=%b ch=%b hi=%h exp 0/0/00/%h", dbg_state, md_annul, md_choose, hi_o, exp_hi);
      end
   endtask

   task automatic test_flush_ready();
      int cyc;
      unit_lat = 3;
      @(negedge clk);
      drive_ex(DIVU, 32'd9, 32'd2);
      cyc = 0;
      @(negedge clk);
      while (md_ready !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
      total++; if (cyc >= 100) begin bad++; $display("FAIL flush_ready_timeout got=0 exp=1"); end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; idle_ex();
      total++; if (dbg_state !== S_ABORT || hi_o !== exp_hi || lo_o !== exp_lo) begin
         bad++; $display("FAIL flush_ready_hilo got st=%0d hi=%h lo=%h exp 3/%h/%h", dbg_state, hi_o, lo_o, exp_hi, exp_lo);
      end
      repeat (2) @(negedge clk);
      total++; if (dbg_state !== S_IDLE || md_choose !== 2'b00) begin bad++; $display("FAIL flush_ready_idle got=%0d/%b exp 0/00", dbg_state, md_choose); end
   endtask

   task automatic test_back_to_back();
      unit_lat = 5;
      issue_and_wait("multu", MULTU, 32'h00010000, 32'h00030000, 2'b11, 1'b0, 32'h00000003, 32'h00000000);
      issue_and_wait("divu2", DIVU, 32'd100, 32'd7, 2'b01, 1'b0, 32'd2, 32'd14);
      @(negedge clk);
      idle_ex();
   endtask

   task automatic test_reset_busy();
      unit_lat = 30;
      @(negedge clk);
      drive_ex(MULT, 32'd3, 32'd4);
      repeat (3) @(negedge clk);
      rst = 1'b1; idle_ex();
      @(negedge clk);
      exp_hi = '0; exp_lo = '0;
      total++;
      if (dbg_state !== S_IDLE || hi_o !== 32'd0 || lo_o !== 32'd0 || md_start !== 1'b0 || md_annul !== 1'b0
          || md_signed !== 1'b0 || md_op1 !== 32'd0 || md_op2 !== 32'd0 || md_choose !== 2'b00 || stall_req !== 1'b0) begin
         bad++; $display("FAIL reset_busy got st=%0d hi=%h lo=%h start=%b sg=%b ch=%b stall=%b exp all zero", dbg_state, hi_o, lo_o, md_start, md_signed, md_choose, stall_req);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_mthi_mtlo();
      test_flush_busy();
      test_flush_ready();
      test_back_to_back();
      test_reset_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
